// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes and the
// controller state encoding.
package alu_share_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_core.sv
// Purely combinational ADD/AND/XOR/SUB datapath with carry / no-borrow flag.
module alu_core
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum  = '0;
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_AND: y = a & b;
            OP_XOR: y = a ^ b;
            default: begin
                // Two's-complement subtract: the carry out means "no borrow".
                sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// held response port and per-requester saturating completion counters.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    state_e             state_q, state_d;
    logic               last_id_q, last_id_d;
    logic               id_q, id_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic               grant_id;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_cout;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .y    (alu_y),
        .cout (alu_cout)
    );

    // Under contention the requester not served last wins; otherwise the sole valid one.
    assign grant_id = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_cout_d = rsp_cout_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena && (req0_valid || req1_valid)) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    id_d       = grant_id;
                    last_id_d  = grant_id;
                    op_d       = grant_id ? req1_op : req0_op;
                    a_d        = grant_id ? req1_a  : req0_a;
                    b_d        = grant_id ? req1_b  : req0_b;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_y;
                rsp_cout_d = alu_cout;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!id_q && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
                    if (id_q && (cnt1_q != '1))  cnt1_d = cnt1_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_id_q  <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            id_q       <= id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_cout_q <= rsp_cout_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scenario bench for alu_share_arbiter: grants and results are scoreboarded
// against an independent arithmetic model; timing checked per scenario.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_op = '0, req1_op = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp_valid, rsp_id, rsp_cout, busy;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] done_cnt0, done_cnt1;

    int checks = 0;
    int failures = 0;
    logic [9:0] sbq[$];
    int acc1 = 0;
    int exp_cnt0 = 0, exp_cnt1 = 0;

    alu_share_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .busy(busy),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    always #5 clk = ~clk;

    // Returns {id, cout, data}; SUB cout written as "a >= b" on purpose.
    function automatic logic [9:0] model(input logic id, input logic [1:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_AND:  s = {1'b0, a & b};
            OP_XOR:  s = {1'b0, a ^ b};
            default: s = {(a >= b), a - b};
        endcase
        return {id, s};
    endfunction

    task automatic sb();
        logic [9:0] exp;
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                checks++;
                if ((req0_ready & req1_ready) !== 1'b0) begin
                    failures++;
                    $display("FAIL one_ready: ready0=%b ready1=%b, at most one required", req0_ready, req1_ready);
                end
            end
            if (req0_ready) sbq.push_back(model(1'b0, req0_op, req0_a, req0_b));
            if (req1_ready) sbq.push_back(model(1'b1, req1_op, req1_a, req1_b));
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: response id=%b data=%h with none expected", rsp_id, rsp_data);
                end else begin
                    exp = sbq.pop_front();
                    if ({rsp_id, rsp_cout, rsp_data} !== exp) begin
                        failures++;
                        $display("FAIL sb_rsp: got id=%b cout=%b data=%h, required id=%b cout=%b data=%h",
                                 rsp_id, rsp_cout, rsp_data, exp[9], exp[8], exp[7:0]);
                    end
                    if (exp[9]) begin
                        acc1++;
                        if (exp_cnt1 < 255) exp_cnt1++;
                    end else if (exp_cnt0 < 255) exp_cnt0++;
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sb();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; ena = 1'b1;
        sbq.delete(); exp_cnt0 = 0; exp_cnt1 = 0; acc1 = 0;
        repeat (2) begin to_neg(); to_pos(); end
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic exp_id, input string nm);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            to_neg();
            if (req0_ready || req1_ready) begin
                seen = 1;
                checks++;
                if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL %s: ready1/ready0=%b%b, required %s", nm, req1_ready, req0_ready, exp_id ? "10" : "01");
                end
            end
            to_pos();
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL %s: no grant within 12 cycles, required requester %0d", nm, exp_id);
        end
    endtask

    task automatic drain(input string nm);
        bit idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            to_neg();
            if (!busy) idle = 1;
            to_pos();
        end
        if (!idle) begin
            checks++; failures++;
            $display("FAIL %s: busy still 1 after 40 cycles, required 0", nm);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_cout, busy, done_cnt0, done_cnt1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b id=%b data=%h cout=%b busy=%b c0=%0d c1=%0d, all 0 required",
                     rsp_valid, rsp_id, rsp_data, rsp_cout, busy, done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_single_add();
        req0_op = OP_ADD; req0_a = 8'hC8; req0_b = 8'h64; req0_valid = 1'b1; rsp_ready = 1'b1;
        to_neg();
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            failures++;
            $display("FAIL add_grant: ready0=%b ready1=%b busy=%b, required 1 0 0", req0_ready, req1_ready, busy);
        end
        to_pos(); req0_valid = 1'b0;
        to_neg();
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL add_n1: busy=%b rsp_valid=%b, required 1 0", busy, rsp_valid);
        end
        to_pos(); to_neg();
        checks++;
        if ({rsp_valid, rsp_id, rsp_cout, rsp_data} !== {3'b101, 8'h2C}) begin
            failures++;
            $display("FAIL add_n2: valid=%b id=%b cout=%b data=%h, required 1 0 1 2c", rsp_valid, rsp_id, rsp_cout, rsp_data);
        end
        to_pos(); to_neg();
        checks++;
        if ({busy, done_cnt0} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL add_count: busy=%b done_cnt0=%0d, required 0 1", busy, done_cnt0);
        end
        to_pos();
    endtask

    task automatic test_contention();
        do_reset();
        req0_op = OP_XOR; req0_a = 8'hF0; req0_b = 8'h3C;
        req1_op = OP_SUB; req1_a = 8'h05; req1_b = 8'h07;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) wait_grant(k[0], "contention_order");
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("contention_drain");
        checks++;
        if ({done_cnt0, done_cnt1} !== {8'd2, 8'd2}) begin
            failures++;
            $display("FAIL contention_counts: c0=%0d c1=%0d, required 2 2", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1;
        wait_grant(1'b0, "bp_grant0");
        req0_valid = 1'b0;
        req1_op = OP_AND; req1_a = 8'hAA; req1_b = 8'h0F; req1_valid = 1'b1;
        to_neg(); to_pos();
        for (int i = 0; i < 10; i++) begin
            to_neg();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready} !== {2'b10, 8'h03, 3'b100}) begin
                failures++;
                $display("FAIL bp_hold: valid=%b id=%b data=%h busy=%b rdy0=%b rdy1=%b, required 1 0 03 1 0 0",
                         rsp_valid, rsp_id, rsp_data, busy, req0_ready, req1_ready);
            end
            to_pos();
        end
        rsp_ready = 1'b1;
        to_neg(); to_pos(); to_neg();
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_regrant: ready1=%b in first IDLE cycle, required 1", req1_ready);
        end
        to_pos();
        req1_valid = 1'b0;
        drain("bp_drain");
    endtask

    task automatic test_ena();
        bit got = 0;
        ena = 1'b0;
        req0_op = OP_SUB; req0_a = 8'h07; req0_b = 8'h05; req0_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            to_neg();
            checks++;
            if ({req0_ready, req1_ready, busy} !== 3'b000) begin
                failures++;
                $display("FAIL ena_block: rdy0=%b rdy1=%b busy=%b, required 0 0 0", req0_ready, req1_ready, busy);
            end
            to_pos();
        end
        ena = 1'b1;
        wait_grant(1'b0, "ena_grant");
        ena = 1'b0; req0_valid = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            to_neg();
            if (rsp_valid) got = 1;
            to_pos();
        end
        checks++;
        if (got !== 1'b1) begin
            failures++;
            $display("FAIL ena_inflight: rsp_valid never seen with ena low, required response");
        end
        drain("ena_drain");
        checks++;
        if (done_cnt0 !== exp_cnt0[7:0]) begin
            failures++;
            $display("FAIL ena_count: done_cnt0=%0d, required %0d", done_cnt0, exp_cnt0);
        end
        ena = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        req1_op = OP_SUB; req1_a = 8'h10; req1_b = 8'h20; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 1200 && acc1 < 260; i++) begin
            to_neg(); to_pos();
        end
        req1_valid = 1'b0;
        checks++;
        if (acc1 < 260) begin
            failures++;
            $display("FAIL sat_progress: %0d responses accepted, required 260", acc1);
        end
        drain("sat_drain");
        checks++;
        if ({done_cnt1, done_cnt0} !== {8'd255, 8'd0}) begin
            failures++;
            $display("FAIL sat_counts: c1=%0d c0=%0d, required 255 0", done_cnt1, done_cnt0);
        end
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        req0_op = OP_ADD; req0_a = 8'h11; req0_b = 8'h22; req0_valid = 1'b1;
        wait_grant(1'b0, "mid_grant");
        req0_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_exec: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_cout, busy, done_cnt0, done_cnt1} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: valid=%b id=%b data=%h cout=%b busy=%b c0=%0d c1=%0d, all 0 required",
                     rsp_valid, rsp_id, rsp_data, rsp_cout, busy, done_cnt0, done_cnt1);
        end
        sbq.delete(); exp_cnt0 = 0; exp_cnt1 = 0;
        to_neg(); to_pos();
        rst_n = 1'b1;
        req1_op = OP_ADD; req1_a = 8'h01; req1_b = 8'h01;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        wait_grant(1'b0, "mid_first_grant");
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain("mid_drain");
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_ena();
        test_saturation();
        test_reset_mid_op();
        checks++;
        if (sbq.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected responses never seen, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 8-bit ALU (ADD/AND/XOR/SUB) between two requesters in the Tiny Tapeout user project. Each requester presents an operand pair and an opcode with a valid/ready handshake. A round-robin arbiter grants one requester. A three-state FSM captures the operands, computes the result and holds it on a shared response port until accepted. Per-requester saturating completion counters are provided for debug readout on `uo_out`/`uio_out` muxing at top level.

## Interface
- `WIDTH`, 8: operand/result width.
- `CNT_W`, 8: completion counter width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  accept enable; 0 blocks new grants, in-flight op completes.
- `req0_valid`, `req1_valid`  in  1  request pending.
- `req0_ready`, `req1_ready`  out  1  grant/accept strobe (combinational, IDLE only).
- `req0_op`, `req1_op`  in  2  opcode: 00 ADD, 01 AND, 10 XOR, 11 SUB.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_data`  out  WIDTH  result.
- `rsp_cout`  out  1  ADD: carry out; SUB: 1 = no borrow (a ≥ b); AND/XOR: 0.
- `busy`  out  1  FSM not in IDLE.
- `done_cnt0`, `done_cnt1`  out  CNT_W  saturating count of completed responses per requester.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**:
  - If `ena` and any valid, grant one requester: assert its `ready`, latch op/a/b and id, go to EXEC.
  - Else stay in IDLE.
- **Arbitration**:
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ `last_id` wins.
  - `last_id` updates on grant.
  - `last_id` resets to 1, so requester 0 wins the first contention.
- **EXEC**: `alu_core` evaluates the latched operands. Register `rsp_data`/`rsp_cout`, go to RESP.
- **RESP**:
  - `rsp_valid`=1; data, id and cout stay stable.
  - On `rsp_ready`=1: increment `done_cnt[rsp_id]` (saturate at 2^CNT_W−1), go to IDLE.
- **Arithmetic**:
  - ADD: {cout,data} = a+b, computed at WIDTH+1 bits.
  - SUB: {cout,data} = a+~b+1. Data wraps modulo 2^WIDTH.
- `ready` is never asserted outside IDLE. At most one `ready` is high per cycle.
- Requester must hold valid/op/operands until its `ready`. Operands are sampled only on the ready cycle.
- `ena` low during EXEC/RESP does not abort; the response still completes.
- **Reset (any state, asynchronous)**:
  - FSM→IDLE; all outputs 0 (`rsp_valid`, `rsp_id`, `rsp_data`, `rsp_cout`, `busy`, counters).
  - `last_id`=1.
  - The in-flight op is discarded and no count is taken.

## Timing
- Grant at cycle N (ready high in N). `busy`=1 from N+1. `rsp_valid`=1 from N+2.
- `rsp_ready` high at N+2: FSM in IDLE at N+3, next grant possible in N+3. Peak throughput is 1 op / 3 cycles.
- `rsp_ready` low: the response is held indefinitely, with no grants during that time.
- `rsp_ready` in the same cycle `rsp_valid` rises is accepted.
- `rsp_ready` asserted outside RESP is ignored.
- Counter increments are visible the cycle after acceptance.

## Structure
- Package `alu_share_pkg`: opcode localparams (`OP_ADD`, `OP_AND`, `OP_XOR`, `OP_SUB`), FSM state encoding (2-bit: IDLE=0, EXEC=1, RESP=2).
- Sub-module `alu_core`: purely combinational, inputs `op`/`a`/`b`, outputs `y`/`cout`, parameter WIDTH.
- Arbiter, FSM, operand/result registers and counters live in the top module.

## Test plan
- **Single ADD**: req0 ADD 0xC8+0x64 → ready0 at N, `rsp_valid` at N+2, data 0x2C, cout 1, id 0; `done_cnt0`=1 after accept.
- **Contention**: both valid from reset with rsp_ready=1, persistent → grant order 0,1,0,1; responses SUB req1 0x05−0x07 → data 0xFE, cout 0; XOR req0 0xF0^0x3C → 0xCC, cout 0.
- **Backpressure**: rsp_ready low for 10 cycles → result and id stable, no ready asserted, busy=1; release → next grant the cycle after IDLE entry.
- **ena gating**: ena=0 with valid high → no ready for 20 cycles; ena drops during EXEC → response still delivered.
- **Counter saturation**: 260 accepted req1 ops → `done_cnt1`=255, `done_cnt0`=0.
- **Reset mid-op**: assert rst_n low in EXEC → all outputs 0 immediately; after release, req0 and req1 both valid → req0 granted first.
